// File: rtl/tdc_hit_scheduler.sv
// TDC hit scheduler: tags per-channel hits with channel and coarse time, then arbitrates
// them round-robin into a shared first-word-fall-through output FIFO.
module tdc_hit_scheduler #(
  parameter int NCH   = 4,
  parameter int CW    = 16,
  parameter int DEPTH = 16
) (
  input  logic                          CLK,
  input  logic                          RSTb,
  input  logic                          CLEAR,
  input  logic                          ENABLE,
  input  logic                          COARSE_TICK,
  input  logic [NCH*8-1:0]              TIME,
  input  logic [NCH-1:0]                TIME_VALID,
  output logic [$clog2(NCH)+CW+8-1:0]   DOUT,
  output logic                          DOUT_VALID,
  input  logic                          DOUT_RD,
  output logic                          FIFO_FULL,
  output logic [15:0]                   LOST_CNT,
  output logic                          OVF
);

  localparam int CHW = $clog2(NCH);
  localparam int AW  = $clog2(DEPTH);
  localparam int WW  = CHW + CW + 8;

  typedef logic [WW-1:0] word_t;

  logic [CW-1:0]  coarse;
  logic [NCH-1:0] pending;
  logic [7:0]     fine_q   [NCH];
  logic [CW-1:0]  coarse_q [NCH];
  logic [CHW-1:0] last_grant;
  word_t          mem [DEPTH];
  logic [AW:0]    wr_ptr, rd_ptr;

  logic           fifo_empty, fifo_full, rd_en;
  logic           grant_vld;
  logic [CHW-1:0] grant_idx, cand;
  logic [NCH-1:0] cap, drop, latch;
  logic [4:0]     drop_cnt;
  logic [16:0]    lost_sum;

  // Extra pointer MSB distinguishes full from empty when the index bits match.
  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign rd_en      = DOUT_RD & ~fifo_empty;

  // Round-robin search starting just after the last granted channel.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    grant_vld = 1'b0;
    grant_idx = '0;
    cand      = '0;
    if (!fifo_full) begin
      for (int k = 1; k <= NCH; k++) begin
        cand = CHW'((int'(last_grant) + k) % NCH);
        if (!grant_vld && pending[cand]) begin
          grant_vld = 1'b1;
          grant_idx = cand;
        end
      end
    end
  end

  // A hit on a channel being granted this cycle refills it rather than dropping.
  always_comb begin
    cap      = '0;
    drop     = '0;
    latch    = '0;
    drop_cnt = '0;
    for (int i = 0; i < NCH; i++) begin
      cap[i]   = ENABLE & TIME_VALID[i];
      drop[i]  = cap[i] & pending[i] & ~(grant_vld && (grant_idx == CHW'(i)));
      latch[i] = cap[i] & ~drop[i];
      drop_cnt = drop_cnt + 5'(drop[i]);
    end
    lost_sum = {1'b0, LOST_CNT} + 17'(drop_cnt);
  end

  always_ff @(posedge CLK or negedge RSTb) begin
    if (!RSTb) begin
      coarse     <= '0;
      pending    <= '0;
      last_grant <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      LOST_CNT   <= '0;
      OVF        <= 1'b0;
    end else if (CLEAR) begin
      coarse     <= '0;
      pending    <= '0;
      last_grant <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      LOST_CNT   <= '0;
      OVF        <= 1'b0;
    end else begin
      // NOTE: state updates use non-blocking assignments so every register samples pre-edge values.
      if (COARSE_TICK) coarse <= coarse + 1'b1;
      for (int i = 0; i < NCH; i++) begin
        if (latch[i])
          pending[i] <= 1'b1;
        else if (grant_vld && (grant_idx == CHW'(i)))
          pending[i] <= 1'b0;
      end
      if (grant_vld) begin
        last_grant <= grant_idx;
        wr_ptr     <= wr_ptr + 1'b1;
      end
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
      LOST_CNT <= lost_sum[16] ? 16'hFFFF : lost_sum[15:0];
      if (|drop) OVF <= 1'b1;
    end
  end

  // NOTE: hit holding registers and FIFO storage are not reset; pending flags and pointers
  // already mark their contents as invalid.
  always_ff @(posedge CLK) begin
    for (int i = 0; i < NCH; i++) begin
      if (latch[i]) begin
        fine_q[i]   <= TIME[8*i +: 8];
        coarse_q[i] <= coarse;
      end
    end
    if (grant_vld)
      mem[wr_ptr[AW-1:0]] <= {grant_idx, coarse_q[grant_idx], fine_q[grant_idx]};
  end

  assign DOUT_VALID = ~fifo_empty;
  assign FIFO_FULL  = fifo_full;
  assign DOUT       = fifo_empty ? '0 : mem[rd_ptr[AW-1:0]];

endmodule

// File: tb/tb_tdc_hit_scheduler.sv
// Directed bench for tdc_hit_scheduler: table-driven single hits plus hand-written
// sequences for arbitration order, FIFO full/drop, coarse wrap, reset and clear.
module tb_tdc_hit_scheduler;

  logic        CLK = 1'b0;
  logic        RSTb;
  logic        CLEAR, ENABLE, COARSE_TICK, DOUT_RD;
  logic [31:0] TIME;
  logic [3:0]  TIME_VALID;
  logic [25:0] DOUT;
  logic        DOUT_VALID, FIFO_FULL, OVF;
  logic [15:0] LOST_CNT;

  logic        c4_clear, c4_tick, c4_rd;
  logic [31:0] c4_time;
  logic [3:0]  c4_valid;
  logic [13:0] dout4;
  logic        dv4, full4, ovf4;
  logic [15:0] lost4;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 CLK = ~CLK;

  tdc_hit_scheduler #(.NCH(4), .CW(16), .DEPTH(16)) dut (
    .CLK(CLK), .RSTb(RSTb), .CLEAR(CLEAR), .ENABLE(ENABLE), .COARSE_TICK(COARSE_TICK),
    .TIME(TIME), .TIME_VALID(TIME_VALID), .DOUT(DOUT), .DOUT_VALID(DOUT_VALID),
    .DOUT_RD(DOUT_RD), .FIFO_FULL(FIFO_FULL), .LOST_CNT(LOST_CNT), .OVF(OVF)
  );

  tdc_hit_scheduler #(.NCH(4), .CW(4), .DEPTH(16)) dut4 (
    .CLK(CLK), .RSTb(RSTb), .CLEAR(c4_clear), .ENABLE(1'b1), .COARSE_TICK(c4_tick),
    .TIME(c4_time), .TIME_VALID(c4_valid), .DOUT(dout4), .DOUT_VALID(dv4),
    .DOUT_RD(c4_rd), .FIFO_FULL(full4), .LOST_CNT(lost4), .OVF(ovf4)
  );

  typedef struct {
    int          ch;
    logic [7:0]  fine;
    int          ticks;
    logic [25:0] exp;
  } vec_t;

  vec_t vecs [4];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_clear();
    CLEAR = 1'b1;
    step();
    CLEAR = 1'b0;
  endtask

  task automatic pop();
    DOUT_RD = 1'b1;
    step();
    DOUT_RD = 1'b0;
  endtask

  initial begin
    RSTb = 1'b0; CLEAR = 1'b0; ENABLE = 1'b1; COARSE_TICK = 1'b0; DOUT_RD = 1'b0;
    TIME = '0; TIME_VALID = '0;
    c4_clear = 1'b0; c4_tick = 1'b0; c4_rd = 1'b0; c4_time = '0; c4_valid = '0;

    vecs[0] = '{2, 8'h5A, 3, {2'd2, 16'd3, 8'h5A}};
    vecs[1] = '{0, 8'h00, 0, {2'd0, 16'd0, 8'h00}};
    vecs[2] = '{3, 8'hFF, 5, {2'd3, 16'd5, 8'hFF}};
    vecs[3] = '{1, 8'h81, 1, {2'd1, 16'd1, 8'h81}};

    #12;
    check("rst_dout_valid", DOUT_VALID, 1'b0);
    check("rst_dout",       DOUT, 26'd0);
    check("rst_full",       FIFO_FULL, 1'b0);
    check("rst_lost",       LOST_CNT, 16'd0);
    check("rst_ovf",        OVF, 1'b0);
    RSTb = 1'b1;
    step();

    // Single hits with latency and tag checks.
    for (int v = 0; v < 4; v++) begin
      do_clear();
      repeat (vecs[v].ticks) begin
        COARSE_TICK = 1'b1;
        step();
        COARSE_TICK = 1'b0;
      end
      TIME = '0;
      TIME[8*vecs[v].ch +: 8] = vecs[v].fine;
      TIME_VALID[vecs[v].ch]  = 1'b1;
      step();
      TIME_VALID = '0;
      check("single_lat_n1", DOUT_VALID, 1'b0);
      step();
      check("single_lat_n2", DOUT_VALID, 1'b1);
      check("single_word",   DOUT, vecs[v].exp);
      pop();
      check("single_drained", DOUT_VALID, 1'b0);
    end

    // Four simultaneous hits after last_grant=1, popped while still being written.
    do_clear();
    TIME_VALID = 4'b0010;
    step();
    TIME_VALID = '0;
    step();
    pop();
    TIME = {8'h13, 8'h12, 8'h11, 8'h10};
    TIME_VALID = 4'hF;
    step();
    TIME_VALID = '0;
    check("rr_not_yet", DOUT_VALID, 1'b0);
    step();
    DOUT_RD = 1'b1;
    for (int j = 0; j < 4; j++) begin
      logic [1:0] ch;
      ch = 2'((j + 2) % 4);
      check("rr_valid", DOUT_VALID, 1'b1);
      check("rr_word",  DOUT, {ch, 16'd0, 8'h10 + 8'(ch)});
      step();
    end
    DOUT_RD = 1'b0;
    check("rr_empty", DOUT_VALID, 1'b0);
    check("rr_lost",  LOST_CNT, 16'd0);

    // Fill the FIFO from ch0, then hold one hit pending and drop the next.
    do_clear();
    TIME = '0;
    for (int i = 0; i < 16; i++) begin
      TIME[7:0] = 8'(i);
      TIME_VALID = 4'b0001;
      step();
      TIME_VALID = '0;
      step();
    end
    check("full_set",  FIFO_FULL, 1'b1);
    check("full_lost", LOST_CNT, 16'd0);
    TIME[7:0] = 8'hA0;
    TIME_VALID = 4'b0001;
    step();
    TIME_VALID = '0;
    step();
    check("held_full", FIFO_FULL, 1'b1);
    check("held_lost", LOST_CNT, 16'd0);
    check("held_ovf",  OVF, 1'b0);
    TIME[7:0] = 8'hA1;
    TIME_VALID = 4'b0001;
    step();
    TIME_VALID = '0;
    check("drop_lost", LOST_CNT, 16'd1);
    check("drop_ovf",  OVF, 1'b1);
    pop();
    check("pop_blocks_grant", FIFO_FULL, 1'b0);
    check("pop_next_head",    DOUT, {2'd0, 16'd0, 8'h01});
    step();
    check("held_written", FIFO_FULL, 1'b1);
    for (int j = 0; j < 16; j++) begin
      check("full_drain", DOUT, {2'd0, 16'd0, (j < 15) ? 8'(j + 1) : 8'hA0});
      pop();
    end
    check("full_drain_empty", DOUT_VALID, 1'b0);
    check("full_drain_lost",  LOST_CNT, 16'd1);

    // Grant and new hit on the same channel in the same cycle: no drop.
    do_clear();
    TIME[7:0] = 8'h01;
    TIME_VALID = 4'b0001;
    step();
    TIME[7:0] = 8'h02;
    step();
    TIME_VALID = '0;
    check("regrant_lost", LOST_CNT, 16'd0);
    step();
    check("regrant_w0", DOUT, {2'd0, 16'd0, 8'h01});
    pop();
    check("regrant_w1", DOUT, {2'd0, 16'd0, 8'h02});
    pop();
    check("regrant_empty", DOUT_VALID, 1'b0);
    check("regrant_ovf",   OVF, 1'b0);

    // Coarse wrap on the CW=4 instance; the hit on tick 16 is tagged 15.
    c4_clear = 1'b1;
    step();
    c4_clear = 1'b0;
    repeat (15) begin
      c4_tick = 1'b1;
      step();
      c4_tick = 1'b0;
    end
    c4_tick = 1'b1;
    c4_time[15:8] = 8'h77;
    c4_valid = 4'b0010;
    step();
    c4_tick = 1'b0;
    c4_valid = '0;
    step();
    check("wrap_valid", dv4, 1'b1);
    check("wrap_word",  dout4, {2'd1, 4'hF, 8'h77});
    c4_rd = 1'b1;
    step();
    c4_rd = 1'b0;
    c4_time[15:8] = 8'h78;
    c4_valid = 4'b0010;
    step();
    c4_valid = '0;
    step();
    check("wrap_zero", dout4, {2'd1, 4'h0, 8'h78});

    // ENABLE=0 ignores hits; simultaneous drops add; CLEAR wins over a same-cycle hit.
    do_clear();
    ENABLE = 1'b0;
    TIME_VALID = 4'b0010;
    step();
    TIME_VALID = '0;
    step();
    step();
    check("dis_no_word", DOUT_VALID, 1'b0);
    check("dis_no_lost", LOST_CNT, 16'd0);
    ENABLE = 1'b1;
    TIME_VALID = 4'hF;
    step();
    step();
    TIME_VALID = '0;
    check("multi_drop_lost", LOST_CNT, 16'd3);
    check("multi_drop_ovf",  OVF, 1'b1);
    CLEAR = 1'b1;
    TIME_VALID = 4'hF;
    step();
    CLEAR = 1'b0;
    TIME_VALID = '0;
    check("clr_ovf",   OVF, 1'b0);
    check("clr_lost",  LOST_CNT, 16'd0);
    check("clr_empty", DOUT_VALID, 1'b0);
    step();
    step();
    check("clr_no_capture", DOUT_VALID, 1'b0);

    // Asynchronous reset with three words queued.
    do_clear();
    TIME_VALID = 4'hF;
    step();
    step();
    TIME_VALID = '0;
    step();
    step();
    check("pre_rst_valid", DOUT_VALID, 1'b1);
    check("pre_rst_lost",  LOST_CNT, 16'd3);
    #2 RSTb = 1'b0;
    #1;
    check("async_rst_valid", DOUT_VALID, 1'b0);
    check("async_rst_lost",  LOST_CNT, 16'd0);
    check("async_rst_ovf",   OVF, 1'b0);
    check("async_rst_dout",  DOUT, 26'd0);
    #2 RSTb = 1'b1;
    step();
    step();
    check("post_rst_empty", DOUT_VALID, 1'b0);

    // Lost counter saturation with a full FIFO and continuous hits.
    do_clear();
    TIME_VALID = 4'hF;
    repeat (17000) step();
    TIME_VALID = '0;
    check("sat_lost", LOST_CNT, 16'hFFFF);
    check("sat_full", FIFO_FULL, 1'b1);
    check("sat_ovf",  OVF, 1'b1);
    do_clear();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
